// File: rtl/data_memory_responder.sv
// data_memory_responder: word-addressed RV32I data memory answering the core's
// load/store port. One request is accepted on the req_* channel. After
// WAIT_CYCLES extra cycles the access is performed and the result is
// presented on the resp_* channel until the core takes it.
// Optional feature macro: DMEM_ERR_CHECK_EN. When it is defined, misaligned or
// out-of-range addresses are rejected with resp_err=1. When it is undefined,
// addresses wrap modulo DEPTH_WORDS.
module data_memory_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state_r;
  logic [3:0]         wait_cnt_r;
  logic               we_r;
  logic [IDX_W-1:0]   idx_r;
  logic [31:0]        wdata_r;
  logic [3:0]         be_r;
  logic               err_r;
  logic               req_err_s;
  logic [31:0]        mem_r [DEPTH_WORDS];

  // Overwrite the bytes selected by be and keep the other bytes of the old word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

`ifndef DMEM_ERR_CHECK_EN
  // Without range checking, the byte-offset bits and the bits above the index are don't-care.
  logic unused_addr_s;
  assign unused_addr_s = ^{req_addr[31:IDX_W+2], req_addr[1:0]};
`endif

  // Classify the incoming address. A rejected request is decided at acceptance.
  always_comb begin
`ifdef DMEM_ERR_CHECK_EN
    req_err_s = (req_addr[1:0] != 2'b00) || ((req_addr >> (IDX_W + 2)) != 32'd0);
`else
    req_err_s = 1'b0;
`endif
  end

  // Request/response control FSM. All handshake outputs are registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      wait_cnt_r <= 4'd0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      we_r       <= 1'b0;
      idx_r      <= '0;
      wdata_r    <= 32'd0;
      be_r       <= 4'd0;
      err_r      <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            we_r      <= req_we;
            idx_r     <= req_addr[IDX_W+1:2];
            wdata_r   <= req_wdata;
            be_r      <= req_be;
            err_r     <= req_err_s;
            req_ready <= 1'b0;
            if (WAIT_CYCLES > 0) begin
              state_r    <= S_WAIT;
              wait_cnt_r <= 4'(WAIT_CYCLES - 1);
            end else begin
              state_r <= S_RESP;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (wait_cnt_r == 4'd0) begin
            state_r <= S_RESP;
          end else begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
          end
        end
        S_RESP: begin
          // The first RESP cycle performs the access. After that, the response is held until it is taken.
          if (!resp_valid) begin
            resp_valid <= 1'b1;
            resp_err   <= err_r;
            resp_rdata <= (we_r || err_r) ? 32'd0 : mem_r[idx_r];
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
            state_r    <= S_IDLE;
          end
        end
        default: begin
          state_r    <= S_IDLE;
          req_ready  <= 1'b0;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Byte-masked store on RESP entry. The array has no reset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (!reset && (state_r == S_RESP) && !resp_valid && we_r && !err_r) begin
      mem_r[idx_r] <= merge_bytes(mem_r[idx_r], wdata_r, be_r);
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder. Three instances use
// WAIT_CYCLES = 1, 0 and 3 (sel 0, 1, 2). Expected responses are pushed to a
// scoreboard queue when a request is accepted. They are popped and compared
// when the response appears.
module tb_data_memory_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic [2:0]  req_valid_v;
  logic [2:0]  resp_ready_v;
  logic [2:0]  req_ready_v;
  logic [2:0]  resp_valid_v;
  logic [2:0]  resp_err_v;
  logic [31:0] resp_rdata_v [3];

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_m [3][256];
  int          n_checks = 0;
  int          n_fail   = 0;

  data_memory_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_v[0]), .req_ready(req_ready_v[0]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid_v[0]), .resp_ready(resp_ready_v[0]),
    .resp_rdata(resp_rdata_v[0]), .resp_err(resp_err_v[0])
  );

  data_memory_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_v[1]), .req_ready(req_ready_v[1]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid_v[1]), .resp_ready(resp_ready_v[1]),
    .resp_rdata(resp_rdata_v[1]), .resp_err(resp_err_v[1])
  );

  data_memory_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_v[2]), .req_ready(req_ready_v[2]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid_v[2]), .resp_ready(resp_ready_v[2]),
    .resp_rdata(resp_rdata_v[2]), .resp_err(resp_err_v[2])
  );

  function automatic int wait_of(input int sel);
    case (sel)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic logic exp_err(input logic [31:0] a);
`ifdef DMEM_ERR_CHECK_EN
    return (a[1:0] != 2'b00) || (a >= 32'd1024);
`else
    return 1'b0;
`endif
  endfunction

  // Issue one request on instance sel (called at a negedge), score it, and
  // optionally complete the response handshake.
  task automatic do_req(input int sel, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input bit auto_ack, input string name);
    int          cnt;
    exp_t        e;
    exp_t        got;
    logic [7:0]  idx;
    logic [31:0] w;
    logic        rr_save;
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    req_valid_v[sel] = 1'b1;
    cnt = 0;
    while (!req_ready_v[sel] && cnt < 50) begin
      @(posedge clk); @(negedge clk); cnt++;
    end
    if (!req_ready_v[sel]) begin
      n_checks++; n_fail++;
      $display("FAIL %s accept: req_ready=%b required 1", name, req_ready_v[sel]);
      req_valid_v[sel] = 1'b0;
      return;
    end
    idx   = addr[9:2];
    e.err = exp_err(addr);
    if (e.err) begin
      e.rdata = 32'd0;
    end else if (we) begin
      e.rdata = 32'd0;
      w = model_m[sel][idx];
      for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
      model_m[sel][idx] = w;
    end else begin
      e.rdata = model_m[sel][idx];
    end
    sb_q.push_back(e);
    @(posedge clk); @(negedge clk);
    req_valid_v[sel] = 1'b0;
    cnt = 0;
    while (!resp_valid_v[sel] && cnt < 50) begin
      @(posedge clk); @(negedge clk); cnt++;
    end
    got = sb_q.pop_front();
    n_checks++;
    if (cnt !== 1 + wait_of(sel)) begin
      n_fail++;
      $display("FAIL %s latency: got %0d edges required %0d", name, cnt, 1 + wait_of(sel));
      return;
    end
    n_checks++;
    if (resp_rdata_v[sel] !== got.rdata) begin
      n_fail++;
      $display("FAIL %s rdata: got %h required %h", name, resp_rdata_v[sel], got.rdata);
    end
    n_checks++;
    if (resp_err_v[sel] !== got.err) begin
      n_fail++;
      $display("FAIL %s err: got %b required %b", name, resp_err_v[sel], got.err);
    end
    if (auto_ack) begin
      rr_save = resp_ready_v[sel];
      resp_ready_v[sel] = 1'b1;
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (resp_valid_v[sel] !== 1'b0 || req_ready_v[sel] !== 1'b1) begin
        n_fail++;
        $display("FAIL %s complete: resp_valid=%b req_ready=%b required 0 1",
                 name, resp_valid_v[sel], req_ready_v[sel]);
      end
      resp_ready_v[sel] = rr_save;
    end
  endtask

  task automatic check_reset_outputs(input int sel, input string name);
    n_checks++;
    if (req_ready_v[sel] !== 1'b0 || resp_valid_v[sel] !== 1'b0 ||
        resp_rdata_v[sel] !== 32'd0 || resp_err_v[sel] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: req_ready=%b resp_valid=%b rdata=%h err=%b required 0 0 0 0",
               name, req_ready_v[sel], resp_valid_v[sel], resp_rdata_v[sel], resp_err_v[sel]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) check_reset_outputs(s, "reset_values");
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (req_ready_v !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_release req_ready: got %b required 111", req_ready_v);
    end
  endtask

  task automatic test_store_load();
    do_req(0, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 1'b1, "sw_40");
    do_req(0, 1'b0, 32'h40, 32'h0, 4'hF, 1'b1, "lw_40");
  endtask

  task automatic test_byte_mask();
    do_req(0, 1'b1, 32'h8, 32'h11223344, 4'hF, 1'b1, "sw_8_full");
    do_req(0, 1'b1, 32'h8, 32'hAABBCCDD, 4'b0101, 1'b1, "sw_8_be0101");
    do_req(0, 1'b0, 32'h8, 32'h0, 4'h0, 1'b1, "lw_8_masked");
    do_req(0, 1'b1, 32'h8, 32'hFFFFFFFF, 4'b0000, 1'b1, "sw_8_be0000");
    do_req(0, 1'b0, 32'h8, 32'h0, 4'h3, 1'b1, "lw_8_after_noop");
  endtask

  task automatic test_backpressure();
    do_req(0, 1'b1, 32'h20, 32'hFEEDFACE, 4'hF, 1'b1, "bp_store");
    do_req(0, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, "bp_load");
    // A new request is presented while the response is stalled and must be ignored.
    req_we = 1'b0; req_addr = 32'h40; req_valid_v[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (resp_valid_v[0] !== 1'b1 || resp_rdata_v[0] !== 32'hFEEDFACE || req_ready_v[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: resp_valid=%b rdata=%h req_ready=%b required 1 feedface 0",
                 i, resp_valid_v[0], resp_rdata_v[0], req_ready_v[0]);
      end
    end
    req_valid_v[0]  = 1'b0;
    resp_ready_v[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (resp_valid_v[0] !== 1'b0 || req_ready_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: resp_valid=%b req_ready=%b required 0 1", resp_valid_v[0], req_ready_v[0]);
    end
    resp_ready_v[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (resp_valid_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_ignored_req: resp_valid=%b required 0", resp_valid_v[0]);
    end
  endtask

  task automatic test_back_to_back();
    resp_ready_v[1] = 1'b1;
    do_req(1, 1'b1, 32'h0, 32'hA5A50001, 4'hF, 1'b1, "b2b_sw0");
    do_req(1, 1'b1, 32'h4, 32'h5A5A0002, 4'hF, 1'b1, "b2b_sw4");
    for (int i = 0; i < 6; i++) begin
      do_req(1, 1'b0, (i % 2 == 0) ? 32'h0 : 32'h4, 32'h0, 4'hF, 1'b1, "b2b_lw");
    end
  endtask

  task automatic test_reset_mid();
    int cnt;
    do_req(2, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 1'b1, "rm_old");
    // This store is abandoned by the reset, so it never enters the scoreboard or the model.
    req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h12345678; req_be = 4'hF;
    req_valid_v[2] = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid_v[2] = 1'b0;
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outputs(2, "reset_mid_values");
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    while (!req_ready_v[2] && cnt < 10) begin
      @(posedge clk); @(negedge clk); cnt++;
    end
    do_req(2, 1'b0, 32'h10, 32'h0, 4'hF, 1'b1, "rm_load_old");
  endtask

  task automatic test_addr_range();
    do_req(0, 1'b1, 32'h0, 32'h0BADCAFE, 4'hF, 1'b1, "ar_sw0");
    do_req(0, 1'b1, 32'h400, 32'h77777777, 4'hF, 1'b1, "ar_sw400");
    do_req(0, 1'b0, 32'h402, 32'h0, 4'hF, 1'b1, "ar_lw402");
    do_req(0, 1'b0, 32'h0, 32'h0, 4'hF, 1'b1, "ar_lw0");
  endtask

  initial begin
    reset = 1'b1;
    req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'd0;
    req_valid_v = 3'b000; resp_ready_v = 3'b000;
    for (int s = 0; s < 3; s++) for (int k = 0; k < 256; k++) model_m[s][k] = 32'd0;
    test_reset();
    test_store_load();
    test_byte_mask();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_addr_range();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
